// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR data-stage engine: decodes SETUP, streams descriptor ROM bytes in MAXPKT packets.
// Optional macro DESC_OSCFG_EN: serve Other-Speed-Configuration (type 7) from the hscfg range.
module usb_desc_reader #(
  parameter int unsigned MAXPKT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_setup_valid,
  input  logic [7:0]  i_bmRequestType,
  input  logic [7:0]  i_bRequest,
  input  logic [15:0] i_wValue,
  input  logic [15:0] i_wLength,
  input  logic        i_in_token,
  input  logic [9:0]  i_desc_dev_addr,
  input  logic [9:0]  i_desc_qual_addr,
  input  logic [9:0]  i_desc_hscfg_addr,
  input  logic [9:0]  i_desc_strlang_addr,
  input  logic [9:0]  i_desc_strvendor_addr,
  input  logic [9:0]  i_desc_strproduct_addr,
  input  logic [9:0]  i_desc_strserial_addr,
  input  logic [7:0]  i_desc_dev_len,
  input  logic [7:0]  i_desc_qual_len,
  input  logic [7:0]  i_desc_hscfg_len,
  input  logic [7:0]  i_desc_strvendor_len,
  input  logic [7:0]  i_desc_strproduct_len,
  input  logic [7:0]  i_desc_strserial_len,
  input  logic        i_descrom_have_strings,
  output logic [9:0]  o_descrom_raddr,
  input  logic [7:0]  i_descrom_rdat,
  output logic [7:0]  o_txdat,
  output logic        o_txval,
  input  logic        i_txrdy,
  output logic        o_txlast,
  output logic        o_txzlp,
  output logic        o_stall,
  output logic        o_busy
);
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 8;
  localparam int unsigned PW = 7;
  localparam logic [LW-1:0] PKT_MASK = LW'(MAXPKT - 1);
  localparam logic [PW-1:0] PKT_MAX  = PW'(MAXPKT);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_IN, SEND, STALL} state_t;
  state_t state, state_d;

  logic          req_ok_c, req_ok_q;
  logic [7:0]    type_q, idx_q;
  logic [15:0]   wlen_q;
  logic [AW-1:0] base_q, base_d, desc_base_c;
  logic [LW-1:0] desc_len_c, xfer_len_c;
  logic [LW-1:0] offset_q, offset_d, remain_q, remain_d;
  logic [PW-1:0] pkt_left_q, pkt_left_d;
  logic          zlp_q, zlp_d, oscfg_q, oscfg_d, oscfg_c;
  logic          xfer_c, zlp_fire_c;
  logic          txval_d, txlast_d, busy_d, stall_d;

  // Request validity, judged from the raw SETUP fields
  always_comb begin
    req_ok_c = 1'b0;
    if (i_bmRequestType == 8'h80 && i_bRequest == 8'h06) begin
      case (i_wValue[15:8])
        8'd1, 8'd2, 8'd6: req_ok_c = 1'b1;
        8'd3:             req_ok_c = i_descrom_have_strings && (i_wValue[7:0] <= 8'd3);
`ifdef DESC_OSCFG_EN
        8'd7:             req_ok_c = 1'b1;
`endif
        default:          req_ok_c = 1'b0;
      endcase
    end
  end

  // Descriptor range selection from the latched request
  always_comb begin
    desc_base_c = i_desc_dev_addr;
    desc_len_c  = i_desc_dev_len;
    oscfg_c     = 1'b0;
    case (type_q)
      8'd2: begin desc_base_c = i_desc_hscfg_addr; desc_len_c = i_desc_hscfg_len; end
      8'd6: begin desc_base_c = i_desc_qual_addr;  desc_len_c = i_desc_qual_len;  end
      8'd3: begin
        case (idx_q)
          8'd0:    begin desc_base_c = i_desc_strlang_addr;    desc_len_c = 8'd4; end
          8'd1:    begin desc_base_c = i_desc_strvendor_addr;  desc_len_c = i_desc_strvendor_len; end
          8'd2:    begin desc_base_c = i_desc_strproduct_addr; desc_len_c = i_desc_strproduct_len; end
          default: begin desc_base_c = i_desc_strserial_addr;  desc_len_c = i_desc_strserial_len; end
        endcase
      end
`ifdef DESC_OSCFG_EN
      8'd7: begin desc_base_c = i_desc_hscfg_addr; desc_len_c = i_desc_hscfg_len; oscfg_c = 1'b1; end
`endif
      default: ;
    endcase
    xfer_len_c = (wlen_q < 16'(desc_len_c)) ? wlen_q[LW-1:0] : desc_len_c;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  // Next state, datapath next values and registered output values
  always_comb begin
    state_d    = state;
    base_d     = base_q;
    offset_d   = offset_q;
    remain_d   = remain_q;
    pkt_left_d = pkt_left_q;
    zlp_d      = zlp_q;
    oscfg_d    = oscfg_q;
    zlp_fire_c = 1'b0;
    xfer_c     = o_txval && i_txrdy;
    if (i_setup_valid) begin
      state_d    = LOOKUP;
      offset_d   = '0;
      remain_d   = '0;
      pkt_left_d = '0;
      zlp_d      = 1'b0;
      oscfg_d    = 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          base_d   = desc_base_c;
          remain_d = xfer_len_c;
          oscfg_d  = oscfg_c;
          zlp_d    = (16'(xfer_len_c) < wlen_q) && ((xfer_len_c & PKT_MASK) == '0);
          if (!req_ok_q)                          state_d = STALL;
          else if (xfer_len_c == '0 && !zlp_d)    state_d = IDLE;
          else                                    state_d = WAIT_IN;
        end
        WAIT_IN: begin
          if (i_in_token) begin
            if (remain_q != '0) begin
              state_d    = SEND;
              pkt_left_d = (remain_q > LW'(MAXPKT)) ? PKT_MAX : PW'(remain_q);
            end else begin
              zlp_fire_c = zlp_q;
              zlp_d      = 1'b0;
              state_d    = IDLE;
            end
          end
        end
        SEND: begin
          if (xfer_c) begin
            offset_d   = offset_q + LW'(1);
            remain_d   = remain_q - LW'(1);
            pkt_left_d = pkt_left_q - PW'(1);
            if (pkt_left_q == PW'(1))
              state_d = (remain_d != '0 || zlp_q) ? WAIT_IN : IDLE;
          end
        end
        default: ;
      endcase
    end
    txval_d  = (state_d == SEND);
    txlast_d = txval_d && (pkt_left_d == PW'(1));
    busy_d   = (state_d == LOOKUP) || (state_d == WAIT_IN) || (state_d == SEND);
    stall_d  = i_setup_valid ? !req_ok_c : o_stall;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_ok_q   <= 1'b0;
      type_q     <= '0;
      idx_q      <= '0;
      wlen_q     <= '0;
      base_q     <= '0;
      offset_q   <= '0;
      remain_q   <= '0;
      pkt_left_q <= '0;
      zlp_q      <= 1'b0;
      oscfg_q    <= 1'b0;
      o_txval    <= 1'b0;
      o_txlast   <= 1'b0;
      o_txzlp    <= 1'b0;
      o_stall    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      if (i_setup_valid) begin
        req_ok_q <= req_ok_c;
        type_q   <= i_wValue[15:8];
        idx_q    <= i_wValue[7:0];
        wlen_q   <= i_wLength;
      end
      base_q     <= base_d;
      offset_q   <= offset_d;
      remain_q   <= remain_d;
      pkt_left_q <= pkt_left_d;
      zlp_q      <= zlp_d;
      oscfg_q    <= oscfg_d;
      o_txval    <= txval_d;
      o_txlast   <= txlast_d;
      o_txzlp    <= zlp_fire_c;
      o_stall    <= stall_d;
      o_busy     <= busy_d;
    end
  end

  assign o_descrom_raddr = base_q + AW'(offset_q);
  // Other-speed config reuses the hscfg bytes with the type byte patched
  assign o_txdat = !o_txval ? 8'h00 :
                   (oscfg_q && offset_q == 8'd1) ? 8'h07 : i_descrom_rdat;

endmodule

// File: tb/tb_usb_desc_reader.sv
// Scoreboard bench for usb_desc_reader: two instances (MAXPKT 64 and 16) share stimulus.
module tb_usb_desc_reader;
  typedef struct {logic [7:0] dat; logic last;} exp_t;

  localparam logic [9:0] DEV_A = 10'h000, QUAL_A = 10'h020, HS_A = 10'h040, LANG_A = 10'h080;
  localparam logic [9:0] VEND_A = 10'h090, PROD_A = 10'h0B0, SER_A = 10'h0D0;

  logic CLK = 1'b0;
  logic RESET;
  logic i_setup_valid, i_in_token, i_txrdy, have_str;
  logic [7:0]  bm, br;
  logic [15:0] wv, wl;
  logic [9:0]  raddr64, raddr16;
  logic [7:0]  rdat64, rdat16, txdat64, txdat16;
  logic        txval64, txval16, txlast64, txlast16, zlp64, zlp16;
  logic        stall64, stall16, busy64, busy16;
  logic [7:0]  rom [1024];

  logic        sel16;
  logic [7:0]  m_txdat;
  logic [9:0]  m_raddr;
  logic        m_txval, m_txlast, m_txzlp, m_stall, m_busy;

  int   n_cmp = 0, n_err = 0, pop_cnt = 0, zlp_cnt = 0;
  exp_t exp_q[$];
  logic hold_pend = 1'b0;
  logic [7:0] hold_dat = 8'h00;
  logic rec_stall, rec_busy;

  always #5 CLK = ~CLK;

  assign rdat64 = rom[raddr64];
  assign rdat16 = rom[raddr16];
  assign m_txdat  = sel16 ? txdat16  : txdat64;
  assign m_raddr  = sel16 ? raddr16  : raddr64;
  assign m_txval  = sel16 ? txval16  : txval64;
  assign m_txlast = sel16 ? txlast16 : txlast64;
  assign m_txzlp  = sel16 ? zlp16    : zlp64;
  assign m_stall  = sel16 ? stall16  : stall64;
  assign m_busy   = sel16 ? busy16   : busy64;

  usb_desc_reader #(.MAXPKT(64)) dut64 (
    .CLK(CLK), .RESET(RESET), .i_setup_valid(i_setup_valid), .i_bmRequestType(bm),
    .i_bRequest(br), .i_wValue(wv), .i_wLength(wl), .i_in_token(i_in_token),
    .i_desc_dev_addr(DEV_A), .i_desc_qual_addr(QUAL_A), .i_desc_hscfg_addr(HS_A),
    .i_desc_strlang_addr(LANG_A), .i_desc_strvendor_addr(VEND_A),
    .i_desc_strproduct_addr(PROD_A), .i_desc_strserial_addr(SER_A),
    .i_desc_dev_len(8'd18), .i_desc_qual_len(8'd10), .i_desc_hscfg_len(8'd32),
    .i_desc_strvendor_len(8'd12), .i_desc_strproduct_len(8'd20), .i_desc_strserial_len(8'd70),
    .i_descrom_have_strings(have_str), .o_descrom_raddr(raddr64), .i_descrom_rdat(rdat64),
    .o_txdat(txdat64), .o_txval(txval64), .i_txrdy(i_txrdy), .o_txlast(txlast64),
    .o_txzlp(zlp64), .o_stall(stall64), .o_busy(busy64));

  usb_desc_reader #(.MAXPKT(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .i_setup_valid(i_setup_valid), .i_bmRequestType(bm),
    .i_bRequest(br), .i_wValue(wv), .i_wLength(wl), .i_in_token(i_in_token),
    .i_desc_dev_addr(DEV_A), .i_desc_qual_addr(QUAL_A), .i_desc_hscfg_addr(HS_A),
    .i_desc_strlang_addr(LANG_A), .i_desc_strvendor_addr(VEND_A),
    .i_desc_strproduct_addr(PROD_A), .i_desc_strserial_addr(SER_A),
    .i_desc_dev_len(8'd18), .i_desc_qual_len(8'd10), .i_desc_hscfg_len(8'd32),
    .i_desc_strvendor_len(8'd12), .i_desc_strproduct_len(8'd20), .i_desc_strserial_len(8'd70),
    .i_descrom_have_strings(have_str), .o_descrom_raddr(raddr16), .i_descrom_rdat(rdat16),
    .o_txdat(txdat16), .o_txval(txval16), .i_txrdy(i_txrdy), .o_txlast(txlast16),
    .o_txzlp(zlp16), .o_stall(stall16), .o_busy(busy16));

  // Monitor: a byte moves when txval and txrdy are both high at the coming edge
  always @(negedge CLK) begin
    if (RESET) begin
      hold_pend = 1'b0;
    end else begin
      exp_t e;
      if (m_txzlp) zlp_cnt++;
      if (m_txval && hold_pend) begin
        n_cmp++;
        if (m_txdat !== hold_dat) begin
          n_err++;
          $display("FAIL hold_stable: txdat %h changed from %h while stalled", m_txdat, hold_dat);
        end
      end
      hold_pend = m_txval && !i_txrdy;
      hold_dat  = m_txdat;
      if (m_txval && i_txrdy) begin
        pop_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %h at addr %h, want none", m_txdat, m_raddr);
        end else begin
          e = exp_q.pop_front();
          if (m_txdat !== e.dat) begin
            n_err++;
            $display("FAIL byte_data: got %h want %h (addr %h)", m_txdat, e.dat, m_raddr);
          end
          n_cmp++;
          if (m_txlast !== e.last) begin
            n_err++;
            $display("FAIL byte_last: got %b want %b (addr %h)", m_txlast, e.last, m_raddr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_desc(input logic [9:0] base, input int len, input int mp, input bit osc);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.dat  = rom[10'(int'(base) + k)];
      if (osc && k == 1) e.dat = 8'h07;
      e.last = (((k + 1) % mp) == 0) || (k + 1 == len);
      exp_q.push_back(e);
    end
  endtask

  // Pulses SETUP, records stall/busy in the LOOKUP cycle, then steps past LOOKUP
  task automatic do_setup(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] v, input logic [15:0] l);
    bm = b0; br = b1; wv = v; wl = l;
    i_setup_valid = 1'b1;
    tick();
    i_setup_valid = 1'b0;
    rec_stall = m_stall;
    rec_busy  = m_busy;
    tick();
  endtask

  task automatic send_in(input bit toggle);
    int n = 0;
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    while (!m_txval && n < 5) begin tick(); n++; end
    n_cmp++;
    if (!m_txval) begin
      n_err++;
      $display("FAIL in_start: txval got 0 want 1 after IN token");
    end
    n = 0;
    while (m_txval && n < 400) begin
      i_txrdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    i_txrdy = 1'b1;
    n_cmp++;
    if (m_txval) begin
      n_err++;
      $display("FAIL in_end: txval still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic finish_xfer(input string nm, input int want_zlp);
    int n = 0;
    while (m_busy && n < 20) begin tick(); n++; end
    n_cmp++;
    if (m_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: busy got %b want 0", nm, m_busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_count: %0d bytes missing, want 0", nm, exp_q.size());
    end
    n_cmp++;
    if (zlp_cnt != want_zlp) begin
      n_err++;
      $display("FAIL %s_zlp: zlp pulses got %0d want %0d", nm, zlp_cnt, want_zlp);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({m_txval, m_txlast, m_txzlp, m_stall, m_busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: val/last/zlp/stall/busy got %b want 00000",
               {m_txval, m_txlast, m_txzlp, m_stall, m_busy});
    end
    n_cmp++;
    if (m_raddr !== 10'h000 || m_txdat !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: raddr %h txdat %h want 000 00", m_raddr, m_txdat);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_dev_full();
    sel16 = 1'b0; zlp_cnt = 0;
    push_desc(DEV_A, 18, 64, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0100, 16'd64);
    n_cmp++;
    if (rec_stall !== 1'b0 || rec_busy !== 1'b1) begin
      n_err++;
      $display("FAIL dev_lookup: stall %b busy %b want 0 1", rec_stall, rec_busy);
    end
    send_in(1'b0);
    finish_xfer("dev_full", 0);
  endtask

  task automatic test_dev_short();
    sel16 = 1'b0; zlp_cnt = 0;
    push_desc(DEV_A, 8, 64, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0100, 16'd8);
    send_in(1'b1);
    finish_xfer("dev_short", 0);
  endtask

  task automatic test_cfg_zlp16();
    sel16 = 1'b1; zlp_cnt = 0;
    push_desc(HS_A, 32, 16, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0200, 16'd255);
    send_in(1'b1);
    send_in(1'b0);
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    n_cmp++;
    if (m_txzlp !== 1'b1 || m_txval !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_zlp_pulse: zlp %b txval %b want 1 0", m_txzlp, m_txval);
    end
    tick();
    n_cmp++;
    if (m_txzlp !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_zlp_width: zlp got %b want 0", m_txzlp);
    end
    finish_xfer("cfg16", 1);
    sel16 = 1'b0;
  endtask

  task automatic test_stall();
    sel16 = 1'b0; zlp_cnt = 0;
    have_str = 1'b1;
    do_setup(8'h80, 8'h06, 16'h0305, 16'd255);
    n_cmp++;
    if (rec_stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_idx5: stall got %b want 1", rec_stall);
    end
    for (int i = 0; i < 6; i++) begin
      i_in_token = i[0];
      tick();
      n_cmp++;
      if (m_stall !== 1'b1 || m_txval !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: stall %b txval %b want 1 0", m_stall, m_txval);
      end
    end
    i_in_token = 1'b0;
    have_str = 1'b0;
    do_setup(8'h80, 8'h06, 16'h0301, 16'd255);
    n_cmp++;
    if (rec_stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_nostr: stall got %b want 1", rec_stall);
    end
    have_str = 1'b1;
    do_setup(8'h00, 8'h06, 16'h0100, 16'd64);
    n_cmp++;
    if (rec_stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_badreq: stall got %b want 1", rec_stall);
    end
    // Valid zero-length request clears the stall and never enters a data stage
    do_setup(8'h80, 8'h06, 16'h0100, 16'd0);
    n_cmp++;
    if (rec_stall !== 1'b0 || m_busy !== 1'b0) begin
      n_err++;
      $display("FAIL wlen0: stall %b busy %b want 0 0", rec_stall, m_busy);
    end
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    repeat (3) tick();
    finish_xfer("wlen0", 0);
  endtask

  task automatic test_strings();
    sel16 = 1'b0; zlp_cnt = 0;
    have_str = 1'b1;
    push_desc(LANG_A, 4, 64, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0300, 16'd255);
    send_in(1'b1);
    finish_xfer("strlang", 0);
    push_desc(SER_A, 70, 64, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0303, 16'd255);
    send_in(1'b0);
    send_in(1'b1);
    finish_xfer("serial", 0);
  endtask

  task automatic test_abort();
    int n = 0;
    int p0;
    sel16 = 1'b0; zlp_cnt = 0;
    push_desc(PROD_A, 20, 64, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0302, 16'd255);
    p0 = pop_cnt;
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    while ((pop_cnt - p0) < 5 && n < 200) begin
      i_txrdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    i_txrdy = 1'b0;
    bm = 8'h80; br = 8'h06; wv = 16'h0100; wl = 16'd64;
    i_setup_valid = 1'b1;
    tick();
    i_setup_valid = 1'b0;
    i_txrdy = 1'b1;
    n_cmp++;
    if (m_txval !== 1'b0 || (pop_cnt - p0) != 5) begin
      n_err++;
      $display("FAIL abort_drop: txval %b bytes %0d want 0 5", m_txval, pop_cnt - p0);
    end
    exp_q.delete();
    push_desc(DEV_A, 18, 64, 1'b0);
    tick();
    send_in(1'b1);
    finish_xfer("abort", 0);
  endtask

  task automatic test_oscfg();
    sel16 = 1'b0; zlp_cnt = 0;
`ifdef DESC_OSCFG_EN
    push_desc(HS_A, 32, 64, 1'b1);
    do_setup(8'h80, 8'h06, 16'h0700, 16'd32);
    n_cmp++;
    if (rec_stall !== 1'b0) begin
      n_err++;
      $display("FAIL oscfg_stall: stall got %b want 0", rec_stall);
    end
    send_in(1'b1);
`else
    do_setup(8'h80, 8'h06, 16'h0700, 16'd32);
    n_cmp++;
    if (rec_stall !== 1'b1 || m_stall !== 1'b1) begin
      n_err++;
      $display("FAIL oscfg_stall: stall %b/%b want 1/1", rec_stall, m_stall);
    end
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    repeat (3) tick();
`endif
    finish_xfer("oscfg", 0);
  endtask

  task automatic test_reset_mid_send();
    sel16 = 1'b1; zlp_cnt = 0;
    push_desc(HS_A, 32, 16, 1'b0);
    do_setup(8'h80, 8'h06, 16'h0200, 16'd255);
    i_in_token = 1'b1;
    tick();
    i_in_token = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (m_txval !== 1'b0) begin
      n_err++;
      $display("FAIL rst_send_drop: txval got %b want 0", m_txval);
    end
    exp_q.delete();
    tick();
    RESET = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      i_in_token = 1'b1;
      tick();
      i_in_token = 1'b0;
      tick();
    end
    finish_xfer("rst_send", 0);
    sel16 = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    sel16 = 1'b0;
    i_setup_valid = 1'b0; i_in_token = 1'b0; i_txrdy = 1'b1; have_str = 1'b1;
    bm = 8'h00; br = 8'h00; wv = 16'h0000; wl = 16'h0000;
    for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 3));
    test_reset();
    test_dev_full();
    test_dev_short();
    test_cfg_zlp16();
    test_stall();
    test_strings();
    test_abort();
    test_oscfg();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_desc_reader.md
USB_DESC_READER -- requirements
Module: usb_desc_reader

Interface
REQ-001 SHALL have parameter MAXPKT, default 64, meaning EP0 max packet size in bytes (legal values: 8, 16, 32, 64).
REQ-002 SHALL have ports CLK in 1 clock; RESET in 1, asynchronous, active-high.
REQ-003 i_setup_valid in 1: one-cycle pulse marking a valid SETUP packet.
REQ-004 i_bmRequestType in 8, i_bRequest in 8, i_wValue in 16, i_wLength in 16: SETUP fields, sampled on i_setup_valid.
REQ-005 i_in_token in 1: one-cycle pulse when the host issues an IN to EP0.
REQ-006 i_desc_dev/qual/hscfg/strlang/strvendor/strproduct/strserial_addr in 10 each: descriptor base addresses.
REQ-007 i_desc_dev/qual/hscfg/strvendor/strproduct/strserial_len in 8 each: descriptor byte lengths; i_descrom_have_strings in 1: string descriptors present.
REQ-008 o_descrom_raddr out 10 and i_descrom_rdat in 8: ROM address and data, combinational read.
REQ-009 o_txdat out 8, o_txval out 1, i_txrdy in 1, o_txlast out 1: byte stream to the EP0 IN buffer; o_txlast marks the last byte of a packet.
REQ-010 o_txzlp out 1: one-cycle pulse requesting a zero-length packet.
REQ-011 o_stall out 1: EP0 stall request; o_busy out 1: data stage in progress.

Function
REQ-012 A GET_DESCRIPTOR request is bmRequestType 0x80 with bRequest 0x06; type = wValue[15:8], index = wValue[7:0].
REQ-013 Type map: 1 -> dev; 6 -> qual; 2 -> hscfg; 3 idx0 -> strlang with fixed length 4; 3 idx1/2/3 -> vendor/product/serial.
REQ-014 Any other request, unmapped type, string index > 3, or type 3 with i_descrom_have_strings=0 SHALL assert o_stall in the cycle after i_setup_valid and hold it until the next i_setup_valid.
REQ-015 States: IDLE, LOOKUP, WAIT_IN, SEND, STALL. i_setup_valid -> LOOKUP, which lasts 1 cycle and latches base and xfer_len = min(desc_len, wLength). LOOKUP then goes to WAIT_IN if the request is valid, else STALL.
REQ-016 WAIT_IN + i_in_token -> SEND. SEND emits min(remaining, MAXPKT) bytes. Each byte transfers when o_txval and i_txrdy are both high. o_txdat = i_descrom_rdat; o_descrom_raddr = base + offset.
REQ-017 After the last byte of a packet: if remaining > 0 or a ZLP is pending -> WAIT_IN, else -> IDLE.
REQ-018 A ZLP is pending when xfer_len < wLength and xfer_len mod MAXPKT = 0. It is served by a WAIT_IN + i_in_token cycle that pulses o_txzlp for 1 cycle with no bytes sent.
REQ-019 wLength = 0 -> no data, no ZLP, back to IDLE after LOOKUP with no stall.
REQ-020 i_setup_valid in any state aborts the current transfer: o_txval drops the next cycle and the new request is decoded.
REQ-021 i_in_token while in IDLE, SEND or STALL SHALL be ignored.
REQ-022 o_txval SHALL stay high with o_txdat stable while i_txrdy is low.
REQ-023 o_busy = 1 in LOOKUP, WAIT_IN and SEND.
REQ-024 The offset counter SHALL be 8 bits and the address add SHALL be 10 bits with no wrap checking; ROM address ranges are guaranteed by construction.

Reset
REQ-025 RESET SHALL force state IDLE and clear all outputs, offset, remaining and ZLP flag to 0.
REQ-026 RESET asserted during SEND SHALL drop o_txval immediately and SHALL NOT emit a ZLP after release.

Configuration
REQ-027 Macro DESC_OSCFG_EN enables Other-Speed-Configuration support.
- Defined: type 7 serves the hscfg range with byte offset 1 replaced by 0x07.
- Undefined: type 7 stalls per REQ-014.

Verification
REQ-028 Device descriptor, wLength=64, MAXPKT=64 -> one 18-byte packet, o_txlast on byte 18, no o_txzlp, return to IDLE.
REQ-029 Device descriptor, wLength=8 -> one 8-byte packet holding ROM bytes 0..7, no ZLP.
REQ-030 MAXPKT=16, config request (type 2), len 32, wLength=255, three IN tokens -> packets of 16 and 16 bytes, then an o_txzlp pulse.
REQ-031 String index 5, and separately type 3 with have_strings=0 -> o_stall high from the cycle after SETUP until the next SETUP; o_txval never asserted.
REQ-032 New SETUP mid-packet with i_txrdy toggling -> o_txval low the next cycle, new descriptor starts at its base address, no byte duplicated.
REQ-033 Type 7, wLength=32: with DESC_OSCFG_EN -> 32 bytes, byte 1 = 0x07; without it -> stall.
